digit_chain_counter: RTL and testbench
======================================

Name: digit_chain_counter

Overview:
Parametrised multi-digit modulo counter for score, move and timer displays. It is built from NDIG cascaded digits, each counting modulo RADIX, so the packed output drives BCD-style displays directly. Beyond a plain enable-and-terminal counter it adds:
- up/down direction
- parallel load
- wrap or saturate mode
- an enable prescaler
- a registered overflow pulse

Parameters:
- NDIG, 2, number of cascaded digits.
- W, 4, bits per digit field; must satisfy 2^W >= RADIX.
- RADIX, 10, modulus of each digit; each digit counts 0..RADIX-1.
- PRESCALE, 1, number of qualified E cycles per count step; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- E  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 1 = saturate at terminal, 0 = wrap.
- load  in  1  parallel load strobe.
- load_val  in  NDIG*W  load value; digit i occupies bits [i*W +: W], digit 0 is least significant.
- C  out  NDIG*W  count value, same packing as load_val.
- T  out  1  terminal flag (combinational).
- ovf  out  1  registered wrap pulse.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk; rst has priority over everything.
- On rst: C = 0, ovf = 0, prescaler count = 0. T then evaluates to 1 if up = 0 and to 0 if up = 1 and NDIG*(RADIX-1) != 0.
- Priority each cycle: rst > load > step > hold.
- Load (load = 1):
  - C takes load_val on the next edge, one-cycle latency.
  - Any digit field >= RADIX is clamped to RADIX-1.
  - Prescaler count clears to 0; ovf = 0.
  - A load in the same cycle as E takes priority; that cycle's E is discarded.
- Prescaler:
  - Internal counter p runs 0..PRESCALE-1 and advances only when E = 1 and load = 0.
  - A step is issued on the cycle where E = 1 and p = PRESCALE-1; p then returns to 0.
  - When PRESCALE = 1, every E cycle is a step.
  - p holds while E = 0.
- Terminal flag: T = 1 when up = 1 and every digit equals RADIX-1, or when up = 0 and every digit equals 0. T is purely combinational on C and up.
- Step, up direction:
  - Digit 0 increments.
  - Digit i increments if every digit below it equals RADIX-1.
  - A digit at RADIX-1 that increments becomes 0.
- Step, down direction: mirror image. A digit at 0 that decrements becomes RADIX-1; digit i decrements if every lower digit equals 0.
- Step with T = 1:
  - sat = 0: the counter wraps (all 0s up, all RADIX-1 down) and ovf = 1 for exactly one cycle.
  - sat = 1: C holds and ovf = 0. The prescaler still cycles.
- ovf is 0 on every cycle that is not a wrapping step.
- Changing direction or mode mid-count:
  - up and sat are sampled per step, with no pipeline.
  - The prescaler is not cleared.
  - A direction flip changes T in the same cycle.
- No illegal digit values are ever produced, whether by count or by load.

Optional Feature:
Macro COUNTER_CMP_EN.
- Defined:
  - Adds input cmp_val [NDIG*W] and output match [1].
  - match is registered: it is 1 on the cycle after C == cmp_val, otherwise 0.
  - Reset value of match is 0.
  - match is evaluated on every cycle regardless of E.
- Undefined: both ports and the comparator logic are absent. All other behaviour is identical.

Decomposition:
- Shared package counter_pkg holds:
  - DIR_UP = 1'b1, DIR_DN = 1'b0
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - a digit-clamp function (min(val, RADIX-1))
- One natural sub-module, digit_cell, is instantiated NDIG times by generate. It is one W-bit modulo-RADIX up/down digit with these signals:
  - inputs: clk, rst, step, up, ld, ld_val
  - outputs: q, at_max, at_zero
- The top level holds the prescaler, the carry/borrow chain (AND of lower at_max/at_zero), T, the saturate gating and ovf.

Test Plan:
All scenarios use NDIG=2, W=4, RADIX=10 and PRESCALE=1 unless stated.
1. rst, then up=1, sat=0, E held 99 cycles -> C=8'h99, T=1. Next E cycle -> C=8'h00, ovf=1 for exactly 1 cycle, then 0.
2. At C=8'h99 with up=1, sat=1, E held 5 cycles -> C stays 8'h99, ovf never asserts.
3. load=1 with load_val=8'h5C -> next cycle C=8'h59 (clamped). Then up=0 with 10 E cycles -> C=8'h49. Check 8'h50->8'h49 borrow.
4. From C=8'h00, up=0, sat=0, 1 E cycle -> C=8'h99, ovf=1. Same stimulus with sat=1 -> C=8'h00, ovf=0.
5. PRESCALE=3 instance: E held 9 cycles -> C=8'h03. E gap of 4 cycles, then 2 E cycles -> C=8'h03 (p held at 2), then 1 more E cycle -> 8'h04.
6. rst, load and E all high in one cycle with C=8'h42 -> C=8'h00, ovf=0, prescaler cleared. Separately, load and E together -> load value wins with no extra step. With COUNTER_CMP_EN, cmp_val=8'h07 -> match=1 on exactly the cycle after C=8'h07.

Source files
------------

// File: rtl/digit_chain_counter_pkg.sv
// Shared constants and helpers for the cascaded digit counter.
// Define COUNTER_CMP_EN at build time to add the registered compare-match output.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Saturate a raw digit field to the largest legal digit value.
    function automatic int clamp_digit(input int val, input int radix);
        return (val > radix - 1) ? radix - 1 : val;
    endfunction

endpackage

// File: rtl/digit_chain_counter_digit_cell.sv
// One W-bit modulo-RADIX up/down digit with parallel load.
// Latency: one cycle from step/ld to q; no backpressure, steps are never stalled.
module digit_cell
    import counter_pkg::*;
#(
    parameter int W     = 4,
    parameter int RADIX = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         at_max,
    output logic         at_zero
);

    localparam logic [W-1:0] MAXV = W'(RADIX - 1);

    assign at_max  = (q == MAXV);
    assign at_zero = (q == '0);

    // ld_val arrives already clamped, so q can never hold an illegal digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                q <= at_max ? '0 : q + W'(1);
            end else begin
                q <= at_zero ? MAXV : q - W'(1);
            end
        end
    end

endmodule

// File: rtl/digit_chain_counter.sv
// Cascaded NDIG-digit modulo-RADIX counter with prescaler, load, wrap/saturate and ovf pulse.
// Latency: one cycle load/step to C; T is combinational; optional COUNTER_CMP_EN adds a registered match.
module digit_chain_counter
    import counter_pkg::*;
#(
    parameter int NDIG     = 2,
    parameter int W        = 4,
    parameter int RADIX    = 10,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              up,
    input  logic              sat,
    input  logic              load,
    input  logic [NDIG*W-1:0] load_val,
`ifdef COUNTER_CMP_EN
    input  logic [NDIG*W-1:0] cmp_val,
    output logic              match,
`endif
    output logic [NDIG*W-1:0] C,
    output logic              T,
    output logic              ovf
);

    localparam int             PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   p;
    logic            p_last;
    logic            step_evt;
    logic            step_go;
    logic [NDIG:0]   chain;
    logic [NDIG-1:0] at_max;
    logic [NDIG-1:0] at_zero;

    assign p_last   = (p == PLAST);
    assign step_evt = E & ~load & p_last;

    // chain[i] says every digit below i is at its rollover value for the current
    // direction; the full chain is exactly the terminal condition.
    assign chain[0] = 1'b1;
    assign T        = chain[NDIG];
    assign step_go  = step_evt & ~(T & (sat == MODE_SAT));

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        logic [W-1:0] ld_val_c;

        assign ld_val_c     = W'(clamp_digit(32'(load_val[i*W +: W]), RADIX));
        assign chain[i+1]   = chain[i] & ((up == DIR_UP) ? at_max[i] : at_zero[i]);

        digit_cell #(
            .W     (W),
            .RADIX (RADIX)
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .step    (step_go & chain[i]),
            .up      (up),
            .ld      (load),
            .ld_val  (ld_val_c),
            .q       (C[i*W +: W]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (load) begin
            p <= '0;
        end else if (E) begin
            p <= p_last ? '0 : p + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= step_evt & T & (sat == MODE_WRAP);
        end
    end

`ifdef COUNTER_CMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else begin
            match <= (C == cmp_val);
        end
    end
`endif

endmodule

// File: tb/tb_digit_chain_counter.sv
// Scoreboard bench: a decimal reference model pushes expected outputs each cycle, tasks pop and compare.
// Two instances share stimulus: PRESCALE=1 (dut1) and PRESCALE=3 (dut3).
module tb_digit_chain_counter;

    logic       clk = 1'b0;
    logic       rst, E, up, sat, load;
    logic [7:0] load_val;
    logic [7:0] c1, c3;
    logic       t1, t3, ovf1, ovf3;
`ifdef COUNTER_CMP_EN
    logic [7:0] cmp_val;
    logic       match1, match3;
`endif

    always #5 clk = ~clk;

    digit_chain_counter #(.NDIG(2), .W(4), .RADIX(10), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .E(E), .up(up), .sat(sat), .load(load), .load_val(load_val),
`ifdef COUNTER_CMP_EN
        .cmp_val(cmp_val), .match(match1),
`endif
        .C(c1), .T(t1), .ovf(ovf1)
    );

    digit_chain_counter #(.NDIG(2), .W(4), .RADIX(10), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .E(E), .up(up), .sat(sat), .load(load), .load_val(load_val),
`ifdef COUNTER_CMP_EN
        .cmp_val(cmp_val), .match(match3),
`endif
        .C(c3), .T(t3), .ovf(ovf3)
    );

    typedef struct {
        logic [7:0] c;
        logic       ovf;
        logic       t;
        logic       mt;
        logic [7:0] c3;
        logic       ovf3;
        logic       t3;
        logic       mt3;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m1_v, m1_p, m3_v, m3_p;
    logic m1_ovf, m3_ovf;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Reference behaviour as a plain integer 0..99, independent of digit structure.
    task automatic model_step(inout int v, inout int p, output logic ov, input int pre);
        int d0, d1;
        ov = 1'b0;
        if (rst) begin
            v = 0;
            p = 0;
        end else if (load) begin
            d0 = int'(load_val[3:0]);
            d1 = int'(load_val[7:4]);
            if (d0 > 9) d0 = 9;
            if (d1 > 9) d1 = 9;
            v = d1 * 10 + d0;
            p = 0;
        end else if (E) begin
            if (p == pre - 1) begin
                p = 0;
                if (up) begin
                    if (v == 99) begin
                        if (!sat) begin v = 0; ov = 1'b1; end
                    end else v = v + 1;
                end else begin
                    if (v == 0) begin
                        if (!sat) begin v = 99; ov = 1'b1; end
                    end else v = v - 1;
                end
            end else begin
                p = p + 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [7:0] lv);
        exp_t       x;
        logic [7:0] pre1, pre3;
        rst = r; E = e; up = u; sat = s; load = l; load_val = lv;
        pre1 = to_bcd(m1_v);
        pre3 = to_bcd(m3_v);
        @(posedge clk);
        model_step(m1_v, m1_p, m1_ovf, 1);
        model_step(m3_v, m3_p, m3_ovf, 3);
        x.c    = to_bcd(m1_v);
        x.ovf  = m1_ovf;
        x.t    = up ? (m1_v == 99) : (m1_v == 0);
        x.c3   = to_bcd(m3_v);
        x.ovf3 = m3_ovf;
        x.t3   = up ? (m3_v == 99) : (m3_v == 0);
`ifdef COUNTER_CMP_EN
        x.mt   = r ? 1'b0 : (pre1 == cmp_val);
        x.mt3  = r ? 1'b0 : (pre3 == cmp_val);
`else
        x.mt   = 1'b0;
        x.mt3  = 1'b0;
        if (pre1 == pre3) x.mt = 1'b0;
`endif
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 0, 1, 8'h42);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h00 || ovf1 !== 1'b0 || t1 !== 1'b0 || c3 !== 8'h00 || ex.c !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_up: C=%h ovf=%b T=%b C3=%h, required C=00 ovf=0 T=0 C3=00", c1, ovf1, t1, c3);
        end
        cycle(1, 0, 0, 0, 0, 8'h00);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== ex.c || t1 !== 1'b1 || t3 !== 1'b1 || ovf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dn_T: C=%h T=%b T3=%b ovf=%b, required C=%h T=1 T3=1 ovf=0", c1, t1, t3, ovf1, ex.c);
        end
    endtask

    task automatic test_wrap_up();
        for (int i = 0; i < 99; i++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (c1 !== ex.c || ovf1 !== ex.ovf || t1 !== ex.t || c3 !== ex.c3 || ovf3 !== ex.ovf3 || t3 !== ex.t3) begin
                n_fail++;
                $display("FAIL count_up[%0d]: C=%h ovf=%b T=%b C3=%h ovf3=%b, required C=%h ovf=%b T=%b C3=%h ovf3=%b",
                         i, c1, ovf1, t1, c3, ovf3, ex.c, ex.ovf, ex.t, ex.c3, ex.ovf3);
            end
        end
        n_checks++;
        if (c1 !== 8'h99 || t1 !== 1'b1) begin
            n_fail++;
            $display("FAIL at_99: C=%h T=%b, required C=99 T=1", c1, t1);
        end
        cycle(0, 1, 1, 0, 0, 8'h00);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h00 || ovf1 !== 1'b1 || ex.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: C=%h ovf=%b, required C=00 ovf=1", c1, ovf1);
        end
        cycle(0, 0, 1, 0, 0, 8'h00);
        ex = sb.pop_front();
        n_checks++;
        if (ovf1 !== 1'b0 || c1 !== ex.c || c3 !== ex.c3) begin
            n_fail++;
            $display("FAIL ovf_pulse_end: ovf=%b C=%h C3=%h, required ovf=0 C=%h C3=%h", ovf1, c1, c3, ex.c, ex.c3);
        end
        up = 1'b0;
        #1;
        n_checks++;
        if (t1 !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_flip_T: T=%b, required 1", t1);
        end
    endtask

    task automatic test_saturate();
        cycle(0, 0, 1, 1, 1, 8'h99);
        ex = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 1, 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (c1 !== 8'h99 || ovf1 !== 1'b0 || c1 !== ex.c || c3 !== ex.c3 || ovf3 !== ex.ovf3) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: C=%h ovf=%b C3=%h, required C=99 ovf=0 C3=%h", i, c1, ovf1, c3, ex.c3);
            end
        end
    endtask

    task automatic test_load_clamp_down();
        cycle(0, 0, 0, 0, 1, 8'h5C);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h59 || c3 !== 8'h59 || ex.c !== 8'h59) begin
            n_fail++;
            $display("FAIL load_clamp: C=%h C3=%h, required 59", c1, c3);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0, 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (c1 !== ex.c || ovf1 !== ex.ovf || t1 !== ex.t || c3 !== ex.c3) begin
                n_fail++;
                $display("FAIL count_dn[%0d]: C=%h ovf=%b T=%b C3=%h, required C=%h ovf=%b T=%b C3=%h",
                         i, c1, ovf1, t1, c3, ex.c, ex.ovf, ex.t, ex.c3);
            end
            if (i == 8) begin
                n_checks++;
                if (c1 !== 8'h50) begin
                    n_fail++;
                    $display("FAIL pre_borrow: C=%h, required 50", c1);
                end
            end
        end
        n_checks++;
        if (c1 !== 8'h49) begin
            n_fail++;
            $display("FAIL borrow: C=%h, required 49", c1);
        end
    endtask

    task automatic test_down_wrap();
        for (int s = 0; s < 2; s++) begin
            cycle(0, 0, 0, 0, 1, 8'h00);
            ex = sb.pop_front();
            cycle(0, 1, 0, logic'(s), 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (c1 !== ex.c || ovf1 !== ex.ovf || c1 !== (s == 0 ? 8'h99 : 8'h00) || ovf1 !== (s == 0)) begin
                n_fail++;
                $display("FAIL down_wrap sat=%0d: C=%h ovf=%b, required C=%h ovf=%b", s, c1, ovf1, ex.c, ex.ovf);
            end
        end
    endtask

    task automatic test_prescale();
        cycle(1, 0, 1, 0, 0, 8'h00);
        ex = sb.pop_front();
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
        end
        n_checks++;
        if (c3 !== 8'h03 || c3 !== ex.c3) begin
            n_fail++;
            $display("FAIL pre3_9: C3=%h, required 03", c3);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
        end
        n_checks++;
        if (c3 !== 8'h03 || c3 !== ex.c3 || c1 !== ex.c) begin
            n_fail++;
            $display("FAIL pre3_hold: C3=%h C=%h, required C3=03 C=%h", c3, c1, ex.c);
        end
        cycle(0, 1, 1, 0, 0, 8'h00);
        ex = sb.pop_front();
        n_checks++;
        if (c3 !== 8'h04 || c3 !== ex.c3) begin
            n_fail++;
            $display("FAIL pre3_step: C3=%h, required 04", c3);
        end
    endtask

    task automatic test_priority();
        cycle(0, 0, 1, 0, 1, 8'h42);
        ex = sb.pop_front();
        cycle(1, 1, 1, 0, 1, 8'h42);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h00 || ovf1 !== 1'b0 || c3 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_prio: C=%h ovf=%b C3=%h, required C=00 ovf=0 C3=00", c1, ovf1, c3);
        end
        // Prescaler cleared by reset: dut3 needs three more E cycles for its first step.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (c3 !== ex.c3 || c1 !== ex.c) begin
                n_fail++;
                $display("FAIL rst_pre[%0d]: C3=%h C=%h, required C3=%h C=%h", i, c3, c1, ex.c3, ex.c);
            end
        end
        cycle(0, 1, 1, 0, 1, 8'h17);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h17 || c3 !== 8'h17 || ovf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prio: C=%h C3=%h ovf=%b, required C=17 C3=17 ovf=0", c1, c3, ovf1);
        end
        cycle(0, 1, 1, 0, 0, 8'h00);
        ex = sb.pop_front();
        n_checks++;
        if (c1 !== 8'h18 || c3 !== ex.c3) begin
            n_fail++;
            $display("FAIL after_load: C=%h C3=%h, required C=18 C3=%h", c1, c3, ex.c3);
        end
    endtask

`ifdef COUNTER_CMP_EN
    task automatic test_match();
        cmp_val = 8'h07;
        cycle(0, 0, 1, 0, 1, 8'h05);
        ex = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0, 0, 8'h00);
            ex = sb.pop_front();
            n_checks++;
            if (match1 !== ex.mt || match3 !== ex.mt3 || match1 !== (i == 2)) begin
                n_fail++;
                $display("FAIL match[%0d]: match=%b match3=%b C=%h, required match=%b match3=%b",
                         i, match1, match3, c1, ex.mt, ex.mt3);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; E = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 8'h00;
`ifdef COUNTER_CMP_EN
        cmp_val = 8'hFF;
`endif
        m1_v = 0; m1_p = 0; m3_v = 0; m3_p = 0;
        m1_ovf = 1'b0; m3_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_wrap_up();
        test_saturate();
        test_load_clamp_down();
        test_down_wrap();
        test_prescale();
        test_priority();
`ifdef COUNTER_CMP_EN
        test_match();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
